// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one DATA_WIDTH-bit full-duplex MSB-first transfer per
// accepted start, with a start/busy/done handshake and fully registered outputs.
module spi_controller #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  ss,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int unsigned DIV_W     = $clog2(CLK_DIV) + 1;
    localparam int unsigned EDGE_W    = $clog2(2 * DATA_WIDTH + 1);
    localparam int unsigned LAST_EDGE = 2 * DATA_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]            r_state,    w_state;
    logic [DIV_W-1:0]      r_div_cnt,  w_div_cnt;
    logic [EDGE_W-1:0]     r_edge_cnt, w_edge_cnt;
    logic [DATA_WIDTH-1:0] r_tx_sr,    w_tx_sr;
    logic [DATA_WIDTH-1:0] r_rx_sr,    w_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data,  w_rx_data;
    logic                  r_ss,       w_ss;
    logic                  r_sclk,     w_sclk;
    logic                  r_mosi,     w_mosi;
    logic                  r_busy,     w_busy;
    logic                  r_done,     w_done;
    logic                  w_tick;

    // One half-period of sclk has elapsed
    assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_ss       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_div_cnt  <= w_div_cnt;
            r_edge_cnt <= w_edge_cnt;
            r_tx_sr    <= w_tx_sr;
            r_rx_sr    <= w_rx_sr;
            r_rx_data  <= w_rx_data;
            r_ss       <= w_ss;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_div_cnt  = r_div_cnt;
        w_edge_cnt = r_edge_cnt;
        w_tx_sr    = r_tx_sr;
        w_rx_sr    = r_rx_sr;
        w_rx_data  = r_rx_data;
        w_ss       = r_ss;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_busy     = r_busy;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_tx_sr    = tx_data;
                    w_ss       = 1'b0;
                    w_mosi     = tx_data[DATA_WIDTH-1];
                    w_busy     = 1'b1;
                    w_div_cnt  = '0;
                    w_edge_cnt = '0;
                    w_state    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_div_cnt  = '0;
                    w_sclk     = 1'b1;
                    w_rx_sr    = {r_rx_sr[DATA_WIDTH-2:0], miso};
                    w_edge_cnt = EDGE_W'(1);
                    w_state    = S_XFER;
                end else begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end
            end
            S_XFER: begin
                if (w_tick) begin
                    w_div_cnt = '0;
                    // After the final falling edge sclk rests low for one half-period
                    if (r_edge_cnt == EDGE_W'(LAST_EDGE)) begin
                        w_state = S_HOLD;
                    end else begin
                        w_edge_cnt = r_edge_cnt + EDGE_W'(1);
                        w_sclk     = ~r_sclk;
                        if (!r_sclk) begin
                            w_rx_sr = {r_rx_sr[DATA_WIDTH-2:0], miso};
                        end else if (r_edge_cnt < EDGE_W'(LAST_EDGE - 1)) begin
                            w_tx_sr = r_tx_sr << 1;
                            w_mosi  = r_tx_sr[DATA_WIDTH-2];
                        end
                    end
                end else begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_div_cnt  = '0;
                    w_edge_cnt = '0;
                    w_ss       = 1'b1;
                    w_mosi     = 1'b0;
                    w_busy     = 1'b0;
                    w_done     = 1'b1;
                    w_rx_data  = r_rx_sr;
                    w_state    = S_IDLE;
                end else begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign ss      = r_ss;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench for spi_controller: a default instance and a CLK_DIV=1
// instance, checked against transfer-level expectations (latency, bit order, edges).
module tb_spi_controller;
    localparam int DW    = 8;
    localparam int DIV0  = 4;
    localparam int DIV1  = 1;
    localparam int LAT0  = DIV0 * (2 * DW + 2);
    localparam int LAT1  = DIV1 * (2 * DW + 2);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start0, busy0, done0, ss0, sclk0, mosi0, miso0, loop0, mconst0;
    logic [DW-1:0] tx0, rx0;
    logic          start1, busy1, done1, ss1, sclk1, mosi1, miso1, loop1;
    logic [DW-1:0] tx1, rx1;

    assign miso0 = loop0 ? mosi0 : mconst0;
    assign miso1 = loop1 ? mosi1 : 1'b0;

    spi_controller #(.DATA_WIDTH(DW), .CLK_DIV(DIV0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .tx_data(tx0), .busy(busy0),
        .done(done0), .rx_data(rx0), .ss(ss0), .sclk(sclk0), .mosi(mosi0), .miso(miso0)
    );
    spi_controller #(.DATA_WIDTH(DW), .CLK_DIV(DIV1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1), .busy(busy1),
        .done(done1), .rx_data(rx1), .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
    );

    int checks = 0;
    int failures = 0;

    // Bus monitor: records every rising sclk edge as a receiving peripheral would see it
    int   ncnt = 0;
    logic sclk0_q = 1'b0, sclk1_q = 1'b0;
    int   rise_t0[$], rise_t1[$];
    logic rise_ss0[$], rise_mosi0[$], rise_ss1[$], rise_mosi1[$];
    int   done_cnt0 = 0;
    always @(negedge clk) begin
        ncnt++;
        if (sclk0 && !sclk0_q) begin
            rise_t0.push_back(ncnt); rise_ss0.push_back(ss0); rise_mosi0.push_back(mosi0);
        end
        if (sclk1 && !sclk1_q) begin
            rise_t1.push_back(ncnt); rise_ss1.push_back(ss1); rise_mosi1.push_back(mosi1);
        end
        sclk0_q = sclk0;
        sclk1_q = sclk1;
        if (done0) done_cnt0++;
    end

    // Drives one transfer on dut0; lat = cycles from accept edge to done (-1 on timeout)
    task automatic run0(input logic [DW-1:0] tx, input bit pre, input int inj,
                        input bit chain, input logic [DW-1:0] ctx,
                        output int lat, output logic ss_at0);
        if (!pre) begin
            @(negedge clk);
            tx0 = tx; start0 = 1'b1;
        end
        rise_t0.delete(); rise_ss0.delete(); rise_mosi0.delete();
        lat = -1;
        ss_at0 = 1'bx;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n == 0) begin
                start0 = 1'b0; tx0 = DW'($urandom); ss_at0 = ss0;
            end
            if (inj > 0 && n == inj) begin start0 = 1'b1; tx0 = 8'hFF; end
            if (inj > 0 && n == inj + 6) start0 = 1'b0;
            if (done0) begin lat = n; break; end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL run0_timeout: no done within 400 cycles (tx=%h)", tx);
        end
        if (chain && lat >= 0) begin tx0 = ctx; start0 = 1'b1; end
    endtask

    task automatic test_reset();
        int lat; logic s0;
        rst_n = 1'b0; start0 = 1'b1; tx0 = 8'hC3; start1 = 1'b0; tx1 = '0;
        loop0 = 1'b1; mconst0 = 1'b0; loop1 = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({ss0, sclk0, mosi0, busy0, done0, rx0} !== {5'b10000, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs0: got ss=%b sclk=%b mosi=%b busy=%b done=%b rx=%h, want 1 0 0 0 0 00",
                     ss0, sclk0, mosi0, busy0, done0, rx0);
        end
        checks++;
        if ({ss1, sclk1, mosi1, busy1, done1, rx1} !== {5'b10000, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs1: got ss=%b sclk=%b mosi=%b busy=%b done=%b rx=%h", ss1, sclk1, mosi1, busy1, done1, rx1);
        end
        rst_n = 1'b1;
        run0(8'hC3, 1'b1, 0, 1'b0, '0, lat, s0);
        checks++;
        if (lat !== LAT0 || rx0 !== 8'hC3) begin
            failures++;
            $display("FAIL reset_first_start: lat=%0d rx=%h, want lat=%0d rx=c3", lat, rx0, LAT0);
        end
    endtask

    task automatic test_loopback();
        int lat; logic s0; logic [DW-1:0] tx;
        loop0 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tx = (t == 0) ? 8'hA5 : DW'($urandom);
            run0(tx, 1'b0, 0, 1'b0, '0, lat, s0);
            checks++;
            if (lat !== LAT0) begin failures++; $display("FAIL loop_latency: got %0d want %0d", lat, LAT0); end
            checks++;
            if (rx0 !== tx) begin failures++; $display("FAIL loop_rx: got %h want %h", rx0, tx); end
            checks++;
            if (busy0 !== 1'b0 || ss0 !== 1'b1) begin
                failures++; $display("FAIL loop_busy_with_done: busy=%b ss=%b want 0 1", busy0, ss0);
            end
            checks++;
            if (rise_t0.size() !== DW) begin failures++; $display("FAIL loop_rise_count: got %0d want %0d", rise_t0.size(), DW); end
            for (int i = 0; i < rise_t0.size() && i < DW; i++) begin
                checks++;
                if (rise_mosi0[i] !== tx[DW-1-i] || rise_ss0[i] !== 1'b0) begin
                    failures++; $display("FAIL loop_bit%0d: mosi=%b ss=%b want mosi=%b ss=0", i, rise_mosi0[i], rise_ss0[i], tx[DW-1-i]);
                end
                if (i > 0) begin
                    checks++;
                    if (rise_t0[i] - rise_t0[i-1] !== 2 * DIV0) begin
                        failures++; $display("FAIL loop_spacing%0d: got %0d want %0d", i, rise_t0[i] - rise_t0[i-1], 2 * DIV0);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0) begin failures++; $display("FAIL loop_done_width: done=%b one cycle later, want 0", done0); end
        end
    endtask

    task automatic test_const_miso();
        int lat; logic s0; logic m; logic [DW-1:0] tx;
        loop0 = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tx = (t < 2) ? 8'h3C : DW'($urandom);
            m  = (t == 0) ? 1'b1 : (t == 1) ? 1'b0 : 1'($urandom);
            mconst0 = m;
            run0(tx, 1'b0, 0, 1'b0, '0, lat, s0);
            checks++;
            if (rx0 !== {DW{m}}) begin failures++; $display("FAIL const_rx: miso=%b got %h want %h", m, rx0, {DW{m}}); end
            for (int i = 0; i < rise_mosi0.size() && i < DW; i++) begin
                checks++;
                if (rise_mosi0[i] !== tx[DW-1-i]) begin
                    failures++; $display("FAIL const_mosi%0d: got %b want %b", i, rise_mosi0[i], tx[DW-1-i]);
                end
            end
        end
        loop0 = 1'b1;
    endtask

    task automatic test_ignore_start();
        int lat; logic s0; logic [DW-1:0] tx;
        loop0 = 1'b1;
        tx = DW'($urandom);
        run0(tx, 1'b0, 20, 1'b0, '0, lat, s0);
        checks++;
        if (lat !== LAT0 || rx0 !== tx) begin
            failures++; $display("FAIL ignore_start: lat=%0d rx=%h want lat=%0d rx=%h", lat, rx0, LAT0, tx);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || ss0 !== 1'b1) begin
            failures++; $display("FAIL ignore_no_restart: busy=%b ss=%b want 0 1", busy0, ss0);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic s0; logic [DW-1:0] a, b;
        a = DW'($urandom); b = DW'($urandom);
        run0(a, 1'b0, 0, 1'b1, b, lat, s0);
        checks++;
        if (rx0 !== a || ss0 !== 1'b1) begin
            failures++; $display("FAIL b2b_first: rx=%h ss=%b want %h 1", rx0, ss0, a);
        end
        run0(b, 1'b1, 0, 1'b0, '0, lat, s0);
        checks++;
        if (s0 !== 1'b0) begin failures++; $display("FAIL b2b_ss_gap: ss=%b one cycle after done, want 0", s0); end
        checks++;
        if (lat !== LAT0 || rx0 !== b) begin
            failures++; $display("FAIL b2b_second: lat=%0d rx=%h want lat=%0d rx=%h", lat, rx0, LAT0, b);
        end
    endtask

    task automatic test_async_reset();
        int lat, dcnt; logic s0; bit seen;
        loop0 = 1'b1;
        rise_t0.delete(); rise_ss0.delete(); rise_mosi0.delete();
        @(negedge clk); tx0 = 8'h96; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rise_t0.size() >= 3) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL areset_wait: only %0d rising edges, want 3", rise_t0.size()); end
        dcnt = done_cnt0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ss0, sclk0, mosi0, busy0, done0} !== 5'b10000) begin
            failures++; $display("FAIL areset_immediate: ss=%b sclk=%b mosi=%b busy=%b done=%b want 1 0 0 0 0", ss0, sclk0, mosi0, busy0, done0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt0 !== dcnt) begin failures++; $display("FAIL areset_no_done: done pulses %0d want %0d", done_cnt0, dcnt); end
        run0(8'h5A, 1'b0, 0, 1'b0, '0, lat, s0);
        checks++;
        if (lat !== LAT0 || rx0 !== 8'h5A) begin
            failures++; $display("FAIL areset_next: lat=%0d rx=%h want lat=%0d rx=5a", lat, rx0, LAT0);
        end
    endtask

    task automatic test_div1();
        int lat; logic [DW-1:0] tx;
        loop1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tx = (t == 0) ? 8'h5A : DW'($urandom);
            @(negedge clk); tx1 = tx; start1 = 1'b1;
            rise_t1.delete(); rise_ss1.delete(); rise_mosi1.delete();
            lat = -1;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (n == 0) begin start1 = 1'b0; tx1 = DW'($urandom); end
                if (done1) begin lat = n; break; end
            end
            checks++;
            if (lat !== LAT1 || rx1 !== tx) begin
                failures++; $display("FAIL div1_xfer: lat=%0d rx=%h want lat=%0d rx=%h", lat, rx1, LAT1, tx);
            end
            checks++;
            if (rise_t1.size() !== DW) begin failures++; $display("FAIL div1_rise_count: got %0d want %0d", rise_t1.size(), DW); end
            for (int i = 0; i < rise_t1.size() && i < DW; i++) begin
                checks++;
                if (rise_mosi1[i] !== tx[DW-1-i] || rise_ss1[i] !== 1'b0) begin
                    failures++; $display("FAIL div1_bit%0d: mosi=%b ss=%b want %b 0", i, rise_mosi1[i], rise_ss1[i], tx[DW-1-i]);
                end
                if (i > 0) begin
                    checks++;
                    if (rise_t1[i] - rise_t1[i-1] !== 2 * DIV1) begin
                        failures++; $display("FAIL div1_spacing%0d: got %0d want %0d", i, rise_t1[i] - rise_t1[i-1], 2 * DIV1);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_const_miso();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first). It drives the ss/sclk/mosi lines that the existing SPI_Peripheral receives, and captures miso. It is used in bench loopback against the peripheral and on a companion controller die that loads the VGA block's configuration. A simple start/busy/done handshake launches one DATA_WIDTH-bit full-duplex transfer per request.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 4, clk cycles per sclk half-period (>=1); sclk period = 2*CLK_DIV clk cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  transfer request; sampled only in IDLE
tx_data  input  DATA_WIDTH  word to send; latched when start is accepted
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when the transfer completes
rx_data  output  DATA_WIDTH  word captured from miso; updated only with done
ss  output  1  slave select, active-low
sclk  output  1  serial clock, idles low
mosi  output  1  serial data out
miso  input  1  serial data in, same clk domain as this block

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, all counters=0. Reset mid-transfer aborts immediately; no done pulse is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, XFER, HOLD.
- IDLE: if start=1 at edge 0:
  - latch tx_data into the tx shift register
  - ss<=0, mosi<=tx_data[DATA_WIDTH-1], busy<=1, done<=0
  - div_cnt<=0, go to SETUP
- SETUP: count CLK_DIV cycles. At edge CLK_DIV: sclk<=1, miso is sampled into rx shift LSB (shift left), edge_cnt<=1, go to XFER.
- XFER: sclk toggles every CLK_DIV cycles, at edges CLK_DIV*k for k=1..2*DATA_WIDTH.
  - Rising toggles (k odd): sample miso.
  - Falling toggles (k even, k<2*DATA_WIDTH): shift the tx register and drive the next bit on mosi.
  - After toggle k=2*DATA_WIDTH, sclk=0: go to HOLD.
- HOLD: wait CLK_DIV cycles. At edge CLK_DIV*(2*DATA_WIDTH+2):
  - ss<=1, mosi<=0, busy<=0, done<=1
  - rx_data<=rx shift register
  - go to IDLE
- done is high for exactly one cycle.
- Latency from the start-accept edge to the done-assert edge is CLK_DIV*(2*DATA_WIDTH+2). For defaults this is 72 cycles.
- Exactly DATA_WIDTH rising sclk edges occur per transfer, all while ss=0. sclk never glitches.
- start while busy=1 is ignored, and tx_data changes during a transfer have no effect.
- start=1 in the done cycle (state IDLE) is accepted. ss is then high for exactly one clk cycle between the transfers.
- rx_data holds its value between transfers.
- div_cnt width is clog2(CLK_DIV)+1 and must wrap cleanly when CLK_DIV=1. edge_cnt width is clog2(2*DATA_WIDTH+1).

Test Plan:
- Reset: hold rst_n=0 with start=1 -> ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0. Release -> the first start is accepted normally.
- Loopback miso=mosi, tx_data=0xA5, defaults:
  - done pulses exactly 72 cycles after start
  - rx_data=0xA5
  - 8 rising sclk edges, each 8 cycles apart, while ss=0
  - busy falls with done
- miso tied 1, tx_data=0x3C -> mosi at successive rising edges = 0,0,1,1,1,1,0,0; rx_data=0xFF. Then miso tied 0 -> rx_data=0x00.
- start re-asserted mid-transfer with tx_data=0xFF -> ignored; result unchanged. start held in the done cycle -> second transfer starts with ss high for exactly 1 cycle.
- Async reset asserted after the 3rd rising sclk edge -> outputs return to reset values without waiting for a clk edge; no done. Next transfer 0x5A loops back correctly.
- CLK_DIV=1, DATA_WIDTH=8 instance, loopback tx_data=0x5A -> sclk period 2 cycles, done at 18 cycles, rx_data=0x5A. Against SPI_Peripheral: the received byte equals tx_data.
